camera_stream_ctrl: RTL and testbench

Frame-level run/stop controller placed between the camera RGB Avalon-ST video source and the downstream VIP pipeline. It lets software start continuous capture, grab a single frame, or stop capture. All switching happens on packet boundaries, so downstream never sees a truncated frame. Packets arriving while capture is disabled are drained and counted, and an Avalon-MM slave exposes control, status, counters and a frame-done interrupt.

---
 rtl/camera_stream_ctrl.sv | 146 ++++++++++++++
 tb/tb_camera_stream_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_ctrl.sv
// Frame-level run/stop gate between a camera Avalon-ST source and the VIP pipeline.
// Optional DROP_CNT register is built only when CAMERA_STREAM_CTRL_DROPCNT_EN is defined.
module camera_stream_ctrl #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  input  logic              src_ready,
  output logic              irq
);

  typedef enum logic [1:0] {ST_STOPPED, ST_WAIT_SOP, ST_PASS} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_src_ready_q;
  logic               r_run;
  logic               r_single;
  logic               r_irq_en;
  logic               r_irq_pend;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [31:0]        r_readdata;
  logic [31:0]        w_rd_mux;
  logic               w_forward;
  logic               w_fwd_eop;
  logic               w_drop_sop;
  logic               w_ctrl_wr;
  logic               w_status_wr;
  logic               w_fcnt_wr;
  logic               w_unused;

  assign w_ctrl_wr   = avs_write && (avs_address == 2'd0);
  assign w_status_wr = avs_write && (avs_address == 2'd1);
  assign w_fcnt_wr   = avs_write && (avs_address == 2'd2);
  assign w_unused    = ^avs_writedata[31:3];

  assign src_data  = snk_data;
  assign src_sop   = snk_sop;
  assign src_eop   = snk_eop;
  assign src_valid = snk_valid & w_forward;
  assign w_fwd_eop  = src_valid & snk_eop;
  assign w_drop_sop = snk_valid & ~w_forward & snk_sop;
  assign irq = r_irq_pend & r_irq_en;
  assign avs_readdata = r_readdata;

  always_comb begin
    w_state_next = r_state;
    w_forward    = 1'b0;
    snk_ready    = 1'b1;
    case (r_state)
      ST_STOPPED: begin
        if (r_run || r_single) w_state_next = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        snk_ready = src_ready;
        w_forward = snk_valid & snk_sop & r_src_ready_q;
        // A one-beat packet (sop and eop together) completes the frame right here.
        if (w_forward) w_state_next = w_fwd_eop ? (r_run ? ST_WAIT_SOP : ST_STOPPED) : ST_PASS;
        else if (!r_run && !r_single) w_state_next = ST_STOPPED;
      end
      ST_PASS: begin
        snk_ready = src_ready;
        w_forward = 1'b1;
        if (w_fwd_eop) w_state_next = r_run ? ST_WAIT_SOP : ST_STOPPED;
      end
      default: w_state_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_STOPPED;
      r_src_ready_q <= 1'b0;
      r_run         <= 1'b0;
      r_single      <= 1'b0;
      r_irq_en      <= 1'b0;
      r_irq_pend    <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_src_ready_q <= src_ready;
      // A software write to CTRL takes priority over the end-of-frame SINGLE clear.
      if (w_ctrl_wr) begin
        r_run    <= avs_writedata[0];
        r_single <= avs_writedata[1];
        r_irq_en <= avs_writedata[2];
      end else if (w_fwd_eop) begin
        r_single <= 1'b0;
      end
      if (w_fwd_eop && r_irq_en) r_irq_pend <= 1'b1;
      else if (w_status_wr && avs_writedata[2]) r_irq_pend <= 1'b0;
      if (w_fcnt_wr) r_frame_cnt <= '0;
      else if (w_fwd_eop) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

`ifdef CAMERA_STREAM_CTRL_DROPCNT_EN
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_dcnt_wr;

  assign w_dcnt_wr = avs_write && (avs_address == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_drop_cnt <= '0;
    else if (w_dcnt_wr) r_drop_cnt <= '0;
    else if (w_drop_sop) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
  end
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop_sop;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      2'd0: w_rd_mux[2:0] = {r_irq_en, r_single, r_run};
      2'd1: w_rd_mux[2:0] = {r_irq_pend, (r_state != ST_STOPPED), (r_state == ST_PASS)};
      2'd2: w_rd_mux[CNT_W-1:0] = r_frame_cnt;
`ifdef CAMERA_STREAM_CTRL_DROPCNT_EN
      2'd3: w_rd_mux[CNT_W-1:0] = r_drop_cnt;
`endif
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else if (avs_read) r_readdata <= w_rd_mux;
  end

endmodule

// File: tb/tb_camera_stream_ctrl.sv
// Directed-plus-random bench for camera_stream_ctrl; the model is a list of expected
// forwarded frames plus frame/drop tallies derived from each scenario's rules.
module tb_camera_stream_ctrl;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata, avs_readdata;
  logic [DW-1:0] snk_data, src_data;
  logic          snk_valid, snk_sop, snk_eop, snk_ready;
  logic          src_valid, src_sop, src_eop, src_ready, irq;

  camera_stream_ctrl #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_ready(snk_ready),
    .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_ready(src_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          frc;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         tx_q[$];
  beat_t         exp_q[$];
  logic [DW+1:0] rx_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_frames = 0;
  int  exp_drops = 0;
  logic prev_rdy = 1'b1;
  bit  chk_stopped = 1'b0;
  bit  chk_track = 1'b0;
  bit  src_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: release strobes, then present the next beat if the source may send.
  task automatic tick();
    beat_t b;
    @(posedge clk); #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
    if (src_rand) src_ready = 1'($urandom_range(0, 1));
    if (tx_q.size() > 0 && (tx_q[0].frc || (prev_rdy && $urandom_range(0, 3) != 0))) begin
      b = tx_q.pop_front();
      snk_valid = 1'b1; snk_sop = b.sop; snk_eop = b.eop; snk_data = b.data;
    end else begin
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = DW'($urandom);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    d = avs_readdata;
  endtask

  task automatic push_frame(input int len, input bit fwd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.frc = 1'b0; b.sop = (i == 0); b.eop = (i == len - 1); b.data = DW'($urandom);
      tx_q.push_back(b);
      if (fwd) exp_q.push_back(b);
    end
    if (fwd) exp_frames++;
    else exp_drops++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (tx_q.size() > 0 && n < 2000) begin tick(); n++; end
    chk(tag, tx_q.size(), 0);
    tx_q.delete();
    repeat (3) tick();
  endtask

  task automatic compare_q(input string tag);
    chk(tag, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(tag, rx_q[i], {exp_q[i].sop, exp_q[i].eop, exp_q[i].data});
    rx_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] drop_exp();
`ifdef CAMERA_STREAM_CTRL_DROPCNT_EN
    return 32'(exp_drops % 65536);
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    prev_rdy <= snk_ready;
    if (reset_n && src_valid) begin
      rx_q.push_back({src_sop, src_eop, src_data});
      chk("passthru", {src_sop, src_eop, src_data}, {snk_sop, snk_eop, snk_data});
    end
    if (chk_stopped) begin
      chk("stop_valid", src_valid, 0);
      chk("stop_ready", snk_ready, 1);
    end
    if (chk_track) chk("track_ready", snk_ready, src_ready);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    beat_t f[6];
    beat_t rem_q[$];
    beat_t b;
    int n;

    reset_n = 1'b0; avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = 32'd0; snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0;
    snk_eop = 1'b0; src_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_snk_ready", snk_ready, 1);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_readdata", avs_readdata, 0);

    // Capture disabled: three frames drained and counted.
    chk_stopped = 1'b1;
    repeat (3) push_frame(5, 1'b0);
    drain("t1_drain");
    chk_stopped = 1'b0;
    compare_q("t1_rx");
    rd(2'd2, d); chk("t1_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t1_dcnt", d, drop_exp());

    // RUN set mid-frame: the tail is discarded, the next frame passes intact.
    push_frame(5, 1'b0);
    n = 0;
    while (tx_q.size() > 2 && n < 200) begin tick(); n++; end
    wr(2'd0, 32'h1);
    drain("t2_drain_a");
    push_frame(5, 1'b1);
    drain("t2_drain_b");
    compare_q("t2_rx");
    rd(2'd2, d); chk("t2_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t2_dcnt", d, drop_exp());

    // SINGLE with IRQ_EN under back-to-back frames.
    wr(2'd0, 32'h0);
    repeat (3) tick();
    wr(2'd0, 32'h6);
    repeat (2) tick();
    push_frame(5, 1'b1);
    push_frame(5, 1'b0);
    push_frame(5, 1'b0);
    drain("t3_drain");
    compare_q("t3_rx");
    rd(2'd0, d); chk("t3_ctrl", d, 32'h4);
    chk("t3_irq_set", irq, 1);
    rd(2'd1, d); chk("t3_status", d, 32'h4);
    wr(2'd1, 32'h4);
    chk("t3_irq_clr", irq, 0);
    rd(2'd1, d); chk("t3_status_clr", d, 32'h0);
    rd(2'd2, d); chk("t3_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t3_dcnt", d, drop_exp());

    // RUN cleared on beat 2 of a 6-beat frame: frame completes, the next is dropped.
    wr(2'd0, 32'h1);
    repeat (2) tick();
    push_frame(6, 1'b1);
    n = 0;
    while (tx_q.size() > 4 && n < 200) begin tick(); n++; end
    wr(2'd0, 32'h0);
    drain("t4_drain_a");
    push_frame(5, 1'b0);
    drain("t4_drain_b");
    compare_q("t4_rx");
    rd(2'd1, d); chk("t4_status", d, 32'h0);
    rd(2'd2, d); chk("t4_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t4_dcnt", d, drop_exp());

    // Random downstream backpressure with a legal source: every frame passes.
    wr(2'd0, 32'h1);
    repeat (2) tick();
    chk_track = 1'b1;
    src_rand = 1'b1;
    for (int i = 0; i < 8; i++) push_frame(int'($urandom_range(2, 7)), 1'b1);
    drain("t5_drain");
    src_rand = 1'b0;
    compare_q("t5_rx");
    // A sop presented right after src_ready was low is discarded and counted.
    src_ready = 1'b0;
    b.frc = 1'b1; b.sop = 1'b1; b.eop = 1'b1; b.data = DW'($urandom);
    tx_q.push_back(b);
    exp_drops++;
    tick();
    src_ready = 1'b1;
    drain("t5_drain_f");
    chk_track = 1'b0;
    compare_q("t5_forced");
    rd(2'd2, d); chk("t5_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t5_dcnt", d, drop_exp());
    wr(2'd2, 32'h0); exp_frames = 0;
    wr(2'd3, 32'h0); exp_drops = 0;
    rd(2'd2, d); chk("t5_fcnt_clr", d, 0);
    rd(2'd3, d); chk("t5_dcnt_clr", d, 0);

    // Reset in the middle of a forwarded frame.
    rd(2'd0, d); chk("t6_ctrl", d, 32'h1);
    for (int i = 0; i < 6; i++) begin
      f[i].frc = 1'b0; f[i].sop = (i == 0); f[i].eop = (i == 5); f[i].data = DW'($urandom);
      tx_q.push_back(f[i]);
    end
    n = 0;
    while (tx_q.size() > 3 && n < 200) begin tick(); n++; end
    chk("t6_wait", tx_q.size(), 3);
    exp_q.push_back(f[0]);
    exp_q.push_back(f[1]);
    #2;
    chk("t6_pre_valid", src_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", src_valid, 0);
    chk("t6_rst_ready", snk_ready, 1);
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_rdata", avs_readdata, 0);
    rem_q = tx_q;
    tx_q.delete();
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    compare_q("t6_partial");
    exp_frames = 0;
    exp_drops = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    rd(2'd0, d); chk("t6_ctrl_rst", d, 0);
    rd(2'd1, d); chk("t6_status_rst", d, 0);
    rd(2'd2, d); chk("t6_fcnt_rst", d, 0);
    wr(2'd0, 32'h1);
    tick();
    foreach (rem_q[i]) tx_q.push_back(rem_q[i]);
    push_frame(5, 1'b1);
    drain("t6_drain");
    chk("t6_first_sop", (rx_q.size() > 0) ? rx_q[0][DW+1] : 1'b0, 1);
    compare_q("t6_rx");
    rd(2'd2, d); chk("t6_fcnt", d, exp_frames);
    rd(2'd3, d); chk("t6_dcnt", d, drop_exp());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
